fifo_word_packer: RTL
=====================

# fifo_word_packer

Downstream read-side stage for the synchronous byte FIFO. It pops DATA_WIDTH-bit entries from the FIFO read port and assembles PACK consecutive entries into one wide word. It presents each word on a valid/ready master interface to the next consumer. An optional flush path emits a partial word with a lane-keep mask.

## Interface
- DATA_WIDTH, 8, width of one FIFO entry (one lane)
- PACK, 4, lanes per output word; power of two, at least 2
- clk  in  1  rising-edge clock, shared with the FIFO
- rst  in  1  asynchronous reset, active-high. One clock; reset is asynchronous and active-high.
- fifo_empty  in  1  FIFO empty flag
- fifo_rd  out  1  read strobe to the FIFO
- fifo_dout  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read
- flush  in  1  request to emit the current partial word
- m_data  out  DATA_WIDTH*PACK  packed word; lane 0 is [DATA_WIDTH-1:0] and holds the first entry
- m_keep  out  PACK  per-lane valid mask
- m_valid  out  1  word available
- m_ready  in  1  consumer accepts word

## Operation
- The FIFO performs a read on every cycle where fifo_rd=1 and fifo_empty=0. fifo_dout holds that entry in the following cycle.
- State register has two states:
  - FILL: lanes are being gathered.
  - HOLD: the word is presented.
- Lane index idx has width log2(PACK)+1. pend is a 1-bit register equal to fifo_rd from the previous cycle.
- fifo_rd is combinational and equals (state==FILL) && !fifo_empty && (idx+pend < PACK) && !flush_req.
- Capture: when pend=1, fifo_dout is written to lane idx of m_data, and idx increments.
- If that capture fills lane PACK-1, then on the same edge:
  - m_valid goes to 1,
  - m_keep becomes all ones,
  - state moves to HOLD.
- In HOLD:
  - No reads are issued.
  - m_data and m_keep are held stable.
  - On the edge where m_valid && m_ready, the block clears m_valid, m_data, m_keep and idx to 0 and returns to FILL.
- flush_req is a sticky request flag:
  - It is set by flush=1 in any state.
  - It is honoured in FILL once pend=0. It then either emits a partial word or is dropped (see Timing).
- No FIFO entry is dropped or duplicated.
- A 1-cycle rst pulse during FILL or HOLD discards the partial or presented word. Any entry read in the cycle before reset is lost.

## Timing
- Reset values: fifo_rd=0, m_valid=0, m_data=0, m_keep=0, state=FILL, idx=0, pend=0, flush_req=0.
- Latency: with the FIFO never empty, fifo_rd is high in cycles 0..PACK-1 and m_valid is high from cycle PACK+1.
- Throughput: one word per PACK+2 cycles when m_ready=1 is held. There are no back-to-back words.
- After a handshake edge, fifo_rd may assert in the very next cycle.
- fifo_empty toggling mid-fill: reads pause and resume. Lane order is preserved.
- m_valid stays asserted until handshake and never drops without one.
- flush with idx>0 and pend=0 in FILL: on the next edge the block enters HOLD with m_valid=1.
  - m_keep has ones for lanes 0..idx-1.
  - Unfilled lanes read 0.
  - flush_req is cleared.
- flush while pend=1: the pending entry is captured first, and the flush is honoured on the following edge.
- flush with idx=0 and pend=0: flush_req is cleared and nothing is emitted.
- flush while in HOLD: it is latched and applies after the handshake, when idx=0. It is therefore dropped.

## Configuration
- FIFO_PACKER_FLUSH_EN defined: flush and flush_req logic are present as described above.
- Undefined:
  - The flush port exists but is ignored.
  - flush_req is constant 0.
  - Partial words remain in FILL indefinitely.
  - m_keep is all ones whenever m_valid=1.

## Test plan
- FIFO preloaded with 0x11,0x22,0x33,0x44 and m_ready=1 -> fifo_rd high in cycles 0-3, m_valid in cycle 5, m_data=0x44332211, m_keep=4'b1111.
- 8 entries 0x01..0x08 with m_ready=0 for 10 cycles after the first word -> m_data holds 0x04030201 with no reads during HOLD, then 0x08070605 follows the release.
- fifo_empty toggling every cycle while filling 0xA0..0xA3 -> word 0xA3A2A1A0 and no extra reads.
- (FIFO_PACKER_FLUSH_EN) two entries 0xBE,0xEF then flush -> m_data=0x0000EFBE, m_keep=4'b0011. Flush with idx=0 -> no m_valid.
- Flush asserted in the same cycle as the 3rd fifo_rd -> the 3rd entry is captured first, m_keep=4'b0111.
- rst asserted asynchronously mid-fill with idx=2 -> all outputs 0 immediately. The next 4 entries form a clean word starting at lane 0.

Source files
------------

// File: rtl/fifo_word_packer_if.sv
// Handshake bundle for fifo_word_packer: FIFO read side in, packed valid/ready word out.
interface fifo_word_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) ();
    logic                         fifo_empty;
    logic                         fifo_rd;
    logic [DATA_WIDTH-1:0]        fifo_dout;
    logic                         flush;
    logic [DATA_WIDTH*PACK-1:0]   m_data;
    logic [PACK-1:0]              m_keep;
    logic                         m_valid;
    logic                         m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  flush,
        input  m_ready,
        output fifo_rd,
        output m_data,
        output m_keep,
        output m_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output flush,
        output m_ready,
        input  fifo_rd,
        input  m_data,
        input  m_keep,
        input  m_valid
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops FIFO entries and packs PACK of them (lane 0 first) into one word on a valid/ready output.
// Partial-word flush with lane-keep mask is compiled in when FIFO_PACKER_FLUSH_EN is defined.
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_word_packer_if.master bus
);
    localparam int IDX_W  = $clog2(PACK) + 1;
    localparam int WORD_W = DATA_WIDTH * PACK;
    localparam logic [IDX_W:0]   PACK_LIM = (IDX_W + 1)'(PACK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_s;
    logic               pend_r;
    logic               flush_req_r;
    logic               flush_req_s;
    logic [WORD_W-1:0]  data_r;
    logic [WORD_W-1:0]  data_s;
    logic [PACK-1:0]    keep_r;
    logic [PACK-1:0]    keep_s;
    logic               valid_r;
    logic               valid_s;
    logic               rd_s;
    logic               flush_go_s;
    logic               handshake_s;

    // Mask with ones for every lane strictly below n.
    function automatic logic [PACK-1:0] lanes_below(input logic [IDX_W-1:0] n);
        logic [PACK-1:0] m;
        m = {PACK{1'b0}};
        for (int i = 0; i < PACK; i++) begin
            m[i] = (IDX_W'(i) < n);
        end
        return m;
    endfunction

    // Returns w with lane `lane` replaced by d.
    function automatic logic [WORD_W-1:0] put_lane(
        input logic [WORD_W-1:0]     w,
        input logic [IDX_W-1:0]      lane,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [WORD_W-1:0] r;
        r = w;
        for (int i = 0; i < PACK; i++) begin
            r[i*DATA_WIDTH +: DATA_WIDTH] = (IDX_W'(i) == lane) ? d : w[i*DATA_WIDTH +: DATA_WIDTH];
        end
        return r;
    endfunction

`ifdef FIFO_PACKER_FLUSH_EN
    // Flush is honoured only once no capture is outstanding.
    always_comb begin
        flush_go_s = 1'b0;
        if (state_r == FILL && flush_req_r && !pend_r) begin
            flush_go_s = 1'b1;
        end else begin
            flush_go_s = 1'b0;
        end
    end
`else
    logic unused_flush_s;
    assign unused_flush_s = bus.flush;

    // Without the flush feature a partial word simply waits for more entries.
    always_comb begin
        flush_go_s = 1'b0;
    end
`endif

    // Read strobe: never ask for more entries than free lanes, counting the one in flight.
    always_comb begin
        rd_s = 1'b0;
        if (!rst && state_r == FILL && !bus.fifo_empty && !flush_req_r &&
            (({1'b0, idx_r} + {{IDX_W{1'b0}}, pend_r}) < PACK_LIM)) begin
            rd_s = 1'b1;
        end else begin
            rd_s = 1'b0;
        end
    end

    // Next-state and output-register logic of the FILL/HOLD machine.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        data_s      = data_r;
        keep_s      = keep_r;
        valid_s     = valid_r;
        flush_req_s = flush_req_r;
        handshake_s = valid_r && bus.m_ready;

        case (state_r)
            FILL: begin
                if (pend_r) begin
                    data_s = put_lane(data_r, idx_r, bus.fifo_dout);
                    idx_s  = idx_r + IDX_W'(1);
                    if (idx_r == LAST_IDX) begin
                        valid_s = 1'b1;
                        keep_s  = {PACK{1'b1}};
                        state_s = HOLD;
                    end else begin
                        state_s = FILL;
                    end
                end else if (flush_go_s) begin
                    flush_req_s = 1'b0;
                    if (idx_r != {IDX_W{1'b0}}) begin
                        valid_s = 1'b1;
                        keep_s  = lanes_below(idx_r);
                        state_s = HOLD;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    valid_s = 1'b0;
                    data_s  = {WORD_W{1'b0}};
                    keep_s  = {PACK{1'b0}};
                    idx_s   = {IDX_W{1'b0}};
                    state_s = FILL;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                valid_s = 1'b0;
                data_s  = {WORD_W{1'b0}};
                keep_s  = {PACK{1'b0}};
                idx_s   = {IDX_W{1'b0}};
                state_s = FILL;
            end
        endcase

`ifdef FIFO_PACKER_FLUSH_EN
        // A new request wins over the clear of an older one on the same edge.
        if (bus.flush) begin
            flush_req_s = 1'b1;
        end else begin
            flush_req_s = flush_req_s;
        end
`else
        flush_req_s = 1'b0;
`endif
    end

    // State, lane index, in-flight read flag and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= FILL;
            idx_r       <= {IDX_W{1'b0}};
            pend_r      <= 1'b0;
            flush_req_r <= 1'b0;
            data_r      <= {WORD_W{1'b0}};
            keep_r      <= {PACK{1'b0}};
            valid_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            pend_r      <= rd_s;
            flush_req_r <= flush_req_s;
            data_r      <= data_s;
            keep_r      <= keep_s;
            valid_r     <= valid_s;
        end
    end

    assign bus.fifo_rd = rd_s;
    assign bus.m_data  = data_r;
    assign bus.m_keep  = keep_r;
    assign bus.m_valid = valid_r;

endmodule
